// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: single-issue ALU plus RV-style multiply/divide unit with valid/ready handshakes.
// Optional macro MDU_FAST_MUL_EN selects a single-cycle combinational multiplier.
`default_nettype none

module alu_mdu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [1:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;

  logic            is_m, accept, a_sgn, b_sgn, a_neg, b_neg, div_ovf;
  logic [3:0]      alu_code;
  logic [XLEN-1:0] alu_res, mag_a, mag_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] mul_hi, mul_lo, div_rem, div_quo;
  logic            div_ge;

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag,
                                               input logic neg, input logic [1:0] sel);
    logic [2*XLEN-1:0] p;
    p = neg ? -mag : mag;
    return (sel == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign in_ready   = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign busy       = (state_q == MUL) || (state_q == DIV);
  assign accept     = in_valid && in_ready && !flush;

  assign is_m  = (ALUOp == 2'b10) && (funct7 == 7'b0000001);
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_code = 4'b0000;
    case (ALUOp)
      2'b00: alu_code = 4'b0000;
      2'b01: alu_code = 4'b1000;
      2'b10: alu_code = {funct7[5], funct3};
      2'b11: alu_code = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
      default: alu_code = 4'b0000;
    endcase
  end

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_code)
      4'b1000: alu_res = op_a - op_b;
      4'b0001: alu_res = op_a << shamt;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = op_a >> shamt;
      4'b1101: alu_res = $signed(op_a) >>> shamt;
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  // Both datapaths work on magnitudes; signs are reapplied at completion.
  assign a_sgn   = funct3[2] ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
  assign b_sgn   = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
  assign a_neg   = a_sgn && op_a[XLEN-1];
  assign b_neg   = b_sgn && op_b[XLEN-1];
  assign mag_a   = a_neg ? -op_a : op_a;
  assign mag_b   = b_neg ? -op_b : op_b;
  assign div_ovf = ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

  assign rem_sh   = {hi_q, lo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign div_ge   = ~rem_diff[XLEN];
  assign div_rem  = div_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_quo  = {lo_q[XLEN-2:0], div_ge};

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;

    case (state_q)
      MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          result_d = mul_pick({mul_hi, mul_lo}, neg_q, f3_q);
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          result_d = f3_q[1] ? (rneg_q ? -div_rem : div_rem)
                             : (neg_q  ? -div_quo : div_quo);
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      f3_d   = funct3[1:0];
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      cnt_d  = '0;
      if (!is_m) begin
        result_d = alu_res;
        state_d  = DONE;
      end else if (!funct3[2]) begin
`ifdef MDU_FAST_MUL_EN
        result_d = mul_pick(fast_prod, a_neg ^ b_neg, funct3[1:0]);
        state_d  = DONE;
`else
        hi_d    = '0;
        lo_d    = mag_b;
        b_d     = mag_a;
        state_d = MUL;
`endif
      end else if (op_b == '0) begin
        result_d = funct3[1] ? op_a : {XLEN{1'b1}};
        state_d  = DONE;
      end else if (div_ovf) begin
        result_d = funct3[1] ? '0 : op_a;
        state_d  = DONE;
      end else begin
        hi_d    = '0;
        lo_d    = mag_a;
        b_d     = mag_b;
        state_d = DIV;
      end
    end

    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu_unit.sv
// tb_alu_mdu_unit: directed self-checking bench for alu_mdu_unit at XLEN=32.
`default_nettype none

module tb_alu_mdu_unit;

  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  alu_mdu_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUOp      (ALUOp),
    .funct7     (funct7),
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    ALUOp    = aop;
    funct7   = f7;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    ALUOp  = 2'($urandom);
  endtask

  // Issue one op, check its latency and result, then let it drain with out_ready high.
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    drive(aop, f7, f3, a, b);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(out_result), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    ALUOp     = 2'b00;
    funct7    = 7'd0;
    funct3    = 3'd0;
    op_a      = '0;
    op_b      = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_result", 64'(out_result), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run_op("ADD",       2'b00, 7'b0000000, 3'b000, 32'd5,          32'd7,          32'd12,         1);
    run_op("SUB",       2'b01, 7'b0000000, 3'b000, 32'd5,          32'd7,          32'hFFFFFFFE,   1);
    run_op("SRAI",      2'b11, 7'b0100000, 3'b101, 32'h80000000,   32'd4,          32'hF8000000,   1);
    run_op("SRLI",      2'b11, 7'b0000000, 3'b101, 32'h80000000,   32'd4,          32'h08000000,   1);
    run_op("ADDI f7",   2'b11, 7'b0100000, 3'b000, 32'd10,         32'd3,          32'd13,         1);
    run_op("SLT",       2'b10, 7'b0000000, 3'b010, 32'hFFFFFFFF,   32'd1,          32'd1,          1);
    run_op("SLTU",      2'b10, 7'b0000000, 3'b011, 32'hFFFFFFFF,   32'd1,          32'd0,          1);
    run_op("XOR",       2'b10, 7'b0000000, 3'b100, 32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   1);
    run_op("SLL shamt", 2'b10, 7'b0000000, 3'b001, 32'd3,          32'h00000021,   32'd6,          1);
    run_op("AND",       2'b10, 7'b0000000, 3'b111, 32'hFF00FF00,   32'h0F0F0F0F,   32'h0F000F00,   1);
    run_op("code1001",  2'b10, 7'b0100000, 3'b001, 32'd2,          32'd3,          32'd5,          1);

    run_op("MUL",       2'b10, 7'b0000001, 3'b000, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   MUL_LAT);
    run_op("MULH",      2'b10, 7'b0000001, 3'b001, 32'h80000000,   32'h80000000,   32'h40000000,   MUL_LAT);
    run_op("MULHU",     2'b10, 7'b0000001, 3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   MUL_LAT);
    run_op("MULHSU",    2'b10, 7'b0000001, 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   MUL_LAT);

    run_op("DIV by0",   2'b10, 7'b0000001, 3'b100, 32'd100,        32'd0,          32'hFFFFFFFF,   1);
    run_op("REM by0",   2'b10, 7'b0000001, 3'b110, 32'd100,        32'd0,          32'd100,        1);
    run_op("DIV ovf",   2'b10, 7'b0000001, 3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
    run_op("REM ovf",   2'b10, 7'b0000001, 3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1);
    run_op("DIV -7/2",  2'b10, 7'b0000001, 3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   DIV_LAT);
    run_op("REM -7/2",  2'b10, 7'b0000001, 3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   DIV_LAT);
    run_op("DIVU",      2'b10, 7'b0000001, 3'b101, 32'd100,        32'd7,          32'd14,         DIV_LAT);
    run_op("REMU",      2'b10, 7'b0000001, 3'b111, 32'd100,        32'd7,          32'd2,          DIV_LAT);

    // Backpressure followed by a back-to-back accept.
    out_ready = 1'b0;
    drive(2'b00, 7'd0, 3'd0, 32'd1, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp first valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      scramble();
      @(posedge clk); #1;
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp hold result", 64'(out_result), 64'd2);
      check("bp in_ready low", 64'(in_ready), 64'd0);
    end
    drive(2'b00, 7'd0, 3'd0, 32'd3, 32'd4);
    out_ready = 1'b1;
    #1;
    check("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b valid", 64'(out_valid), 64'd1);
    check("b2b result", 64'(out_result), 64'd7);
    @(posedge clk); #1;
    check("b2b drained", 64'(out_valid), 64'd0);

    // Flush during DIVU, with a competing in_valid on the flush edge.
    drive(2'b10, 7'b0000001, 3'b101, 32'd1000, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush pre busy", 64'(busy), 64'd1);
    drive(2'b00, 7'd0, 3'd0, 32'd9, 32'd9);
    flush = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush busy", 64'(busy), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush no output", 64'(seen), 64'd0);

    run_op("ADD after flush", 2'b00, 7'd0, 3'd0, 32'd1, 32'd2, 32'd3, 1);

    // Asynchronous reset in the middle of a multiply.
    drive(2'b10, 7'b0000001, 3'b000, 32'd5, 32'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`ifndef MDU_FAST_MUL_EN
    check("mid-MUL busy", 64'(busy), 64'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid-MUL out_valid", 64'(out_valid), 64'd0);
    check("rst mid-MUL out_result", 64'(out_result), 64'd0);
    check("rst mid-MUL busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst release in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst no stale output", 64'(seen), 64'd0);
    run_op("MUL after rst", 2'b10, 7'b0000001, 3'b000, 32'd5, 32'd6, 32'd30, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
